// File: rtl/moe_pkg.sv
// Shared constants and types for the MoE PE-array datapath blocks.
package moe_pkg;

    localparam int unsigned FP16_W   = 16;
    localparam int unsigned PE_LANES = 16;
    localparam int unsigned VEC_W    = FP16_W * PE_LANES;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } coll_state_e;

endpackage

// File: rtl/collector_slot_ram.sv
// Ring of reassembly slots: per-lane writes into any slot, fill masks, and one read port.
module collector_slot_ram import moe_pkg::*; #(
    parameter int unsigned LANES = PE_LANES,
    parameter int unsigned DW    = FP16_W,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             clr_i,
    input  logic [LANES-1:0]                 wr_en_i,
    input  logic [LANES-1:0][PW-1:0]         wr_slot_i,
    input  logic [LANES*DW-1:0]              wr_data_i,
    input  logic                             pop_i,
    input  logic [PW-1:0]                    rptr_i,
    output logic [DEPTH-1:0][LANES-1:0]      mask_o,
    output logic [LANES*DW-1:0]              rd_data_o
);

    logic [DEPTH-1:0][LANES-1:0] mask_q, mask_d;
    logic [LANES*DW-1:0]         data_q [DEPTH];

    // A lane can never write the slot being popped: its mask bit is still set.
    always_comb begin
        mask_d = mask_q;
        if (clr_i) begin
            mask_d = '0;
        end else begin
            if (pop_i) begin
                mask_d[rptr_i] = '0;
            end
            for (int i = 0; i < int'(LANES); i++) begin
                if (wr_en_i[i]) begin
                    mask_d[wr_slot_i[i]][i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int s = 0; s < int'(DEPTH); s++) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (wr_en_i[i] && (wr_slot_i[i] == PW'(s))) begin
                    data_q[s][i*DW +: DW] <= wr_data_i[i*DW +: DW];
                end
            end
        end
    end

    assign mask_o    = mask_q;
    assign rd_data_o = data_q[rptr_i];

endmodule

// File: rtl/output_collector.sv
// Reassembles skewed per-PE FP16 results into in-order 16-lane vectors for the gating stage.
module output_collector import moe_pkg::*; #(
    parameter int unsigned LANES = PE_LANES,
    parameter int unsigned DW    = FP16_W,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cfg_start_i,
    input  logic [CNT_W-1:0]    cfg_vec_num_i,
    output logic                busy_o,
    input  logic [LANES-1:0]    pe_valid_i,
    input  logic [LANES*DW-1:0] pe_data_i,
    output logic [LANES-1:0]    pe_ready_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [LANES*DW-1:0] out_vec_o,
    output logic                out_last_o,
    output logic                done_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    coll_state_e                 state_q, state_d;
    logic [CNT_W-1:0]            n_q, n_d;
    logic [LANES-1:0][PW-1:0]    wptr_q, wptr_d;
    logic [LANES-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]               rptr_q, rptr_d;
    logic [CNT_W-1:0]            out_cnt_q, out_cnt_d;

    logic [DEPTH-1:0][LANES-1:0] mask;
    logic [LANES*DW-1:0]         rd_data;
    logic [LANES-1:0]            wr_en;
    logic                        run;
    logic                        start;
    logic                        pop;

    assign run   = (state_q == StRun);
    assign start = (state_q == StIdle) && cfg_start_i;

    always_comb begin
        pe_ready_o = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            pe_ready_o[i] = run && !mask[wptr_q[i]][i] && (cnt_q[i] < n_q);
        end
    end

    assign wr_en       = pe_valid_i & pe_ready_o;
    assign out_valid_o = run && (&mask[rptr_q]);
    assign pop         = out_valid_o && out_ready_i;
    assign out_last_o  = out_valid_o && (out_cnt_q == (n_q - CNT_W'(1)));
    assign out_vec_o   = out_valid_o ? rd_data : '0;
    assign busy_o      = run;
    assign done_o      = (state_q == StDone);

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        wptr_d    = wptr_q;
        cnt_d     = cnt_q;
        rptr_d    = rptr_q;
        out_cnt_d = out_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (cfg_start_i) begin
                    state_d   = StRun;
                    n_d       = (cfg_vec_num_i == '0) ? CNT_W'(1) : cfg_vec_num_i;
                    wptr_d    = '0;
                    cnt_d     = '0;
                    rptr_d    = '0;
                    out_cnt_d = '0;
                end
            end
            StRun: begin
                for (int i = 0; i < int'(LANES); i++) begin
                    if (wr_en[i]) begin
                        wptr_d[i] = wptr_q[i] + PW'(1);
                        cnt_d[i]  = cnt_q[i] + CNT_W'(1);
                    end
                end
                if (pop) begin
                    rptr_d    = rptr_q + PW'(1);
                    out_cnt_d = out_cnt_q + CNT_W'(1);
                    if (out_last_o) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            n_q       <= '0;
            wptr_q    <= '0;
            cnt_q     <= '0;
            rptr_q    <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            wptr_q    <= wptr_d;
            cnt_q     <= cnt_d;
            rptr_q    <= rptr_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    collector_slot_ram #(
        .LANES (LANES),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_slot_ram (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (start),
        .wr_en_i   (wr_en),
        .wr_slot_i (wptr_q),
        .wr_data_i (pe_data_i),
        .pop_i     (pop),
        .rptr_i    (rptr_q),
        .mask_o    (mask),
        .rd_data_o (rd_data)
    );

endmodule

// File: tb/tb_output_collector.sv
// Directed bench for output_collector: vector table plus hand-written multi-cycle sequences.
module tb_output_collector;

    logic         clk;
    logic         rst_n;
    logic         cfg_start;
    logic [15:0]  cfg_vec_num;
    logic         busy;
    logic [15:0]  pe_valid;
    logic [255:0] pe_data;
    logic [15:0]  pe_ready;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_vec;
    logic         out_last;
    logic         done;

    int n_checks = 0;
    int n_err    = 0;

    output_collector #(
        .LANES (16),
        .DW    (16),
        .DEPTH (4),
        .CNT_W (16)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .cfg_start_i   (cfg_start),
        .cfg_vec_num_i (cfg_vec_num),
        .busy_o        (busy),
        .pe_valid_i    (pe_valid),
        .pe_data_i     (pe_data),
        .pe_ready_o    (pe_ready),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_vec_o     (out_vec),
        .out_last_o    (out_last),
        .done_o        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [15:0] num;
        logic [15:0] valid;
        logic [15:0] base;
        logic        ordy;
        logic        e_busy;
        logic [15:0] e_rdy;
        logic        e_valid;
        logic        e_last;
        logic        e_done;
        logic [15:0] e_base;
    } vec_t;

    vec_t tbl [11];

    function automatic logic [255:0] mk(input logic [15:0] base);
        logic [255:0] v;
        for (int i = 0; i < 16; i++) begin
            v[i*16 +: 16] = base + 16'(i);
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        cfg_start   = 1'b0;
        cfg_vec_num = '0;
        pe_valid    = '0;
        pe_data     = '0;
        out_ready   = 1'b0;

        // aligned lanes, N=3
        tbl[0]  = '{1'b1, 16'd3, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h0};
        tbl[1]  = '{1'b0, 16'd0, 16'hFFFF, 16'h3C00, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'h3C00};
        tbl[2]  = '{1'b0, 16'd0, 16'hFFFF, 16'h3C10, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'h3C10};
        tbl[3]  = '{1'b0, 16'd0, 16'hFFFF, 16'h3C20, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h3C20};
        tbl[4]  = '{1'b0, 16'd0, 16'hFFFF, 16'h3C30, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0};
        tbl[5]  = '{1'b0, 16'd0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0};
        // N=0 treated as 1; start during RUN ignored; extra pe_valid refused
        tbl[6]  = '{1'b1, 16'd0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h0};
        tbl[7]  = '{1'b1, 16'd5, 16'hFFFF, 16'h1000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h1000};
        tbl[8]  = '{1'b0, 16'd0, 16'hFFFF, 16'h2000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h1000};
        tbl[9]  = '{1'b0, 16'd0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0};
        tbl[10] = '{1'b0, 16'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0};

        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ready", pe_ready, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_vec", out_vec, 0);
        chk("rst_last", out_last, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        step();

        for (int k = 0; k < 11; k++) begin
            cfg_start   = tbl[k].start;
            cfg_vec_num = tbl[k].num;
            pe_valid    = tbl[k].valid;
            pe_data     = mk(tbl[k].base);
            out_ready   = tbl[k].ordy;
            step();
            chk($sformatf("tbl%0d_busy", k), busy, tbl[k].e_busy);
            chk($sformatf("tbl%0d_ready", k), pe_ready, tbl[k].e_rdy);
            chk($sformatf("tbl%0d_valid", k), out_valid, tbl[k].e_valid);
            chk($sformatf("tbl%0d_last", k), out_last, tbl[k].e_last);
            chk($sformatf("tbl%0d_done", k), done, tbl[k].e_done);
            chk($sformatf("tbl%0d_vec", k), out_vec, tbl[k].e_valid ? mk(tbl[k].e_base) : '0);
        end
        cfg_start = 1'b0;

        // skew: lane i starts at cycle i, N=2
        cfg_start = 1'b1; cfg_vec_num = 16'd2; out_ready = 1'b0; pe_valid = '0;
        step();
        cfg_start = 1'b0;
        for (int c = 0; c < 17; c++) begin
            for (int i = 0; i < 16; i++) begin
                pe_valid[i] = (c >= i);
                pe_data[i*16 +: 16] = (c >= i) ? (16'h4000 + 16'((c - i) * 256) + 16'(i)) : 16'h0;
            end
            step();
            chk($sformatf("skew_valid_c%0d", c), out_valid, (c >= 15));
            if (c >= 15) chk("skew_vec0", out_vec, mk(16'h4000));
        end
        chk("skew_last0", out_last, 0);
        pe_valid = '0; out_ready = 1'b1;
        step();
        chk("skew_vec1", out_vec, mk(16'h4100));
        chk("skew_last1", out_last, 1);
        step();
        chk("skew_done", done, 1);
        step();
        chk("skew_idle", busy, 0);

        // backpressure / full, N=8
        cfg_start = 1'b1; cfg_vec_num = 16'd8; out_ready = 1'b0; pe_valid = '0;
        step();
        cfg_start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            pe_valid = 16'hFFFF;
            pe_data  = mk(16'h5000 + 16'(k * 16));
            step();
            chk($sformatf("bp_ready_k%0d", k), pe_ready, (k < 3) ? 16'hFFFF : 16'h0000);
            chk($sformatf("bp_vec_k%0d", k), out_vec, mk(16'h5000));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_ready_after_pop", pe_ready, 16'hFFFF);
        chk("bp_vec_after_pop", out_vec, mk(16'h5010));
        pe_data = mk(16'h5040);
        step();
        chk("bp_refull", pe_ready, 16'h0000);
        pe_valid = '0; out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("bp_drain%0d", j), out_vec, mk(16'h5010 + 16'(j * 16)));
            step();
        end
        chk("bp_empty", out_valid, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        // slow lane 7, N=4
        cfg_start = 1'b1; cfg_vec_num = 16'd4; out_ready = 1'b1; pe_valid = '0;
        step();
        cfg_start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            pe_valid = 16'hFF7F;
            pe_data  = mk(16'h6000 + 16'(k * 16));
            step();
            chk($sformatf("slow_valid_k%0d", k), out_valid, 0);
            chk($sformatf("slow_ready_k%0d", k), pe_ready, (k < 3) ? 16'hFFFF : 16'h0080);
        end
        for (int m = 0; m < 4; m++) begin
            pe_valid = 16'h0080;
            pe_data  = mk(16'h6000 + 16'(m * 16));
            step();
            chk($sformatf("slow_valid_m%0d", m), out_valid, 1);
            chk($sformatf("slow_vec_m%0d", m), out_vec, mk(16'h6000 + 16'(m * 16)));
            chk($sformatf("slow_last_m%0d", m), out_last, (m == 3));
        end
        pe_valid = '0;
        step();
        chk("slow_done", done, 1);
        step();
        chk("slow_idle", busy, 0);

        // reset mid-job, N=5
        cfg_start = 1'b1; cfg_vec_num = 16'd5; out_ready = 1'b1; pe_valid = '0;
        step();
        cfg_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            pe_valid = 16'hFFFF;
            pe_data  = mk(16'h7000 + 16'(k * 16));
            step();
        end
        chk("mid_pre_valid", out_valid, 1);
        rst_n = 1'b0; pe_valid = '0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_valid", out_valid, 0);
        chk("mid_ready", pe_ready, 0);
        chk("mid_vec", out_vec, 0);
        chk("mid_last", out_last, 0);
        chk("mid_done", done, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("mid_nodone", done, 0);
        chk("mid_idle", busy, 0);
        cfg_start = 1'b1; cfg_vec_num = 16'd1; out_ready = 1'b0;
        step();
        cfg_start = 1'b0;
        pe_valid = 16'hFFFF; pe_data = mk(16'h7100);
        step();
        pe_valid = '0;
        chk("new_vec", out_vec, mk(16'h7100));
        chk("new_last", out_last, 1);
        out_ready = 1'b1;
        step();
        chk("new_done", done, 1);
        step();
        chk("new_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
